// File: rtl/wr_rsp_fifo_reader.sv
// Write-response FIFO consumer: pops one packet at a time, checks its framing and
// hands BID/BRESP to the host over valid/ready, with saturating response statistics.
//
// state | meaning
// IDLE  | waiting for a non-empty FIFO
// RD    | read_enable high, pop in flight
// CAP   | fifo_rdata valid, framing checked, fields captured
// OUT   | response held on rsp_* until the host handshake
module wr_rsp_fifo_reader #(
  parameter int id_wid = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [127:0]      fifo_rdata,
  output logic              read_enable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [id_wid-1:0] rsp_bid,
  output logic [1:0]        rsp_bresp,
  output logic              frame_err,
  input  logic              clear_stats,
  output logic [15:0]       okay_cnt,
  output logic [15:0]       slverr_cnt,
  output logic [15:0]       decerr_cnt,
  output logic [15:0]       frame_err_cnt
);

  // Field boundaries below SOP move with the BID width.
  localparam int P_BID_LO = 120 - id_wid;
  localparam int P_RSP_LO = P_BID_LO - 4;
  localparam int P_EOP_LO = P_RSP_LO - 8;
  localparam int P_RSV_HI = P_EOP_LO - 1;

  localparam logic [7:0]  P_SOP = 8'hAA;
  localparam logic [7:0]  P_EOP = 8'h53;
  localparam logic [15:0] P_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_read_enable;
  logic                r_rsp_valid;
  logic [id_wid-1:0]   r_rsp_bid;
  logic [1:0]          r_rsp_bresp;
  logic                r_frame_err;
  logic [15:0]         r_okay_cnt;
  logic [15:0]         r_slverr_cnt;
  logic [15:0]         r_decerr_cnt;
  logic [15:0]         r_frame_err_cnt;

  logic [7:0]          w_sop;
  logic [id_wid-1:0]   w_bid;
  logic [3:0]          w_bresp4;
  logic [7:0]          w_eop;
  logic                w_rsv_zero;
  logic                w_frame_ok;
  logic                w_cap;
  logic                w_inc_okay;
  logic                w_inc_slverr;
  logic                w_inc_decerr;
  logic                w_inc_ferr;

  assign w_sop      = fifo_rdata[127:120];
  assign w_bid      = fifo_rdata[119:P_BID_LO];
  assign w_bresp4   = fifo_rdata[P_BID_LO-1:P_RSP_LO];
  assign w_eop      = fifo_rdata[P_RSP_LO-1:P_EOP_LO];
  assign w_rsv_zero = (fifo_rdata[P_RSV_HI:0] == '0);

  assign w_frame_ok = (w_sop == P_SOP) && (w_eop == P_EOP) &&
                      (w_bresp4[3:2] == 2'b00) && w_rsv_zero;

  // Statistics follow the CAP evaluation, not the host handshake.
  assign w_cap        = (r_state == S_CAP);
  assign w_inc_okay   = w_cap && w_frame_ok && !w_bresp4[1];
  assign w_inc_slverr = w_cap && w_frame_ok && (w_bresp4[1:0] == 2'b10);
  assign w_inc_decerr = w_cap && w_frame_ok && (w_bresp4[1:0] == 2'b11);
  assign w_inc_ferr   = w_cap && !w_frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_read_enable <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_bid     <= '0;
      r_rsp_bresp   <= 2'b00;
      r_frame_err   <= 1'b0;
    end else begin
      r_read_enable <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            r_state       <= S_RD;
            r_read_enable <= 1'b1;
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (w_frame_ok) begin
            r_rsp_bid   <= w_bid;
            r_rsp_bresp <= w_bresp4[1:0];
            r_rsp_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_OUT: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Clear takes priority over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_okay_cnt      <= 16'd0;
      r_slverr_cnt    <= 16'd0;
      r_decerr_cnt    <= 16'd0;
      r_frame_err_cnt <= 16'd0;
    end else if (clear_stats) begin
      r_okay_cnt      <= 16'd0;
      r_slverr_cnt    <= 16'd0;
      r_decerr_cnt    <= 16'd0;
      r_frame_err_cnt <= 16'd0;
    end else begin
      if (w_inc_okay && (r_okay_cnt != P_SAT))
        r_okay_cnt <= r_okay_cnt + 16'd1;
      if (w_inc_slverr && (r_slverr_cnt != P_SAT))
        r_slverr_cnt <= r_slverr_cnt + 16'd1;
      if (w_inc_decerr && (r_decerr_cnt != P_SAT))
        r_decerr_cnt <= r_decerr_cnt + 16'd1;
      if (w_inc_ferr && (r_frame_err_cnt != P_SAT))
        r_frame_err_cnt <= r_frame_err_cnt + 16'd1;
    end
  end

  assign read_enable   = r_read_enable;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_bid       = r_rsp_bid;
  assign rsp_bresp     = r_rsp_bresp;
  assign frame_err     = r_frame_err;
  assign okay_cnt      = r_okay_cnt;
  assign slverr_cnt    = r_slverr_cnt;
  assign decerr_cnt    = r_decerr_cnt;
  assign frame_err_cnt = r_frame_err_cnt;

endmodule

// File: tb/tb_wr_rsp_fifo_reader.sv
// Bench for wr_rsp_fifo_reader: FIFO model, directed corner sequences, a vector table
// and a randomized run scored against a packet-level reference model.
module tb_wr_rsp_fifo_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic [127:0] fifo_rdata;
  logic         read_enable;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [3:0]   rsp_bid;
  logic [1:0]   rsp_bresp;
  logic         frame_err;
  logic         clear_stats;
  logic [15:0]  okay_cnt, slverr_cnt, decerr_cnt, frame_err_cnt;

  wr_rsp_fifo_reader #(.id_wid(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .read_enable(read_enable), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bid(rsp_bid), .rsp_bresp(rsp_bresp), .frame_err(frame_err),
    .clear_stats(clear_stats), .okay_cnt(okay_cnt), .slverr_cnt(slverr_cnt),
    .decerr_cnt(decerr_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: word appears on fifo_rdata the cycle after a sampled read_enable.
  logic [127:0] mem [0:1023];
  int           wp = 0;
  int           rp = 0;
  logic [127:0] r_rdata = '0;
  always @(posedge clk) begin
    if (read_enable && (rp != wp)) begin
      r_rdata <= mem[rp % 1024];
      rp      <= rp + 1;
    end
  end
  assign fifo_rdata = r_rdata;
  assign fifo_empty = (wp == rp);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] pkt);
    mem[wp % 1024] = pkt;
    wp++;
  endtask

  task automatic do_clear();
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
  endtask

  function automatic logic [127:0] mk(input logic [7:0] sop, input logic [3:0] bid,
                                      input logic [3:0] br, input logic [7:0] eop,
                                      input logic [103:0] low);
    return {sop, bid, br, eop, low};
  endfunction

  // Wait for either a response or a frame error, bounded.
  task automatic wait_out(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid || frame_err) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    if (!seen) chk({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [127:0] pkt;
    logic         good;
    logic [3:0]   bid;
    logic [1:0]   bresp;
  } vec_t;

  vec_t vt [9];

  logic [3:0]  last_bid;
  logic [1:0]  last_bresp;
  int          n_re, n_unstable, n_fe, n_val;
  int          v_cyc [4];
  logic [5:0]  v_val [4];
  int          e_ok, e_slv, e_dec, e_fe;
  logic [5:0]  exp_q [$];

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; clear_stats = 1'b0;
    vt[0] = '{mk(8'hAA, 4'h0, 4'h0, 8'h53, 104'h0), 1'b1, 4'h0, 2'd0};
    vt[1] = '{mk(8'hAA, 4'hF, 4'h1, 8'h53, 104'h0), 1'b1, 4'hF, 2'd1};
    vt[2] = '{mk(8'hAA, 4'h3, 4'h3, 8'h53, 104'h0), 1'b1, 4'h3, 2'd3};
    vt[3] = '{mk(8'hAB, 4'h1, 4'h0, 8'h53, 104'h0), 1'b0, 4'h0, 2'd0};
    vt[4] = '{mk(8'hAA, 4'h2, 4'h0, 8'h52, 104'h0), 1'b0, 4'h0, 2'd0};
    vt[5] = '{mk(8'hAA, 4'h2, 4'h4, 8'h53, 104'h0), 1'b0, 4'h0, 2'd0};
    vt[6] = '{mk(8'hAA, 4'h7, 4'h2, 8'h53, {1'b1, 103'h0}), 1'b0, 4'h0, 2'd0};
    vt[7] = '{mk(8'hAA, 4'hA, 4'h2, 8'h53, 104'h0), 1'b1, 4'hA, 2'd2};
    vt[8] = '{mk(8'hAA, 4'h6, 4'h8, 8'h53, 104'h0), 1'b0, 4'h0, 2'd0};

    // Reset state
    repeat (3) cyc();
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_bid, rsp_bresp}), 32'd0);
    chk("rst_counters", 32'(okay_cnt | slverr_cnt | decerr_cnt | frame_err_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("idle_empty_no_read", 32'(read_enable), 32'd0);

    // Single good packet: latency and SLVERR count
    rsp_ready = 1'b1;
    push(mk(8'hAA, 4'h5, 4'h2, 8'h53, 104'h0));
    chk("single_re_c0", 32'(read_enable), 32'd0);
    cyc();
    chk("single_re_c1", 32'(read_enable), 32'd1);
    cyc();
    chk("single_re_c2", 32'(read_enable), 32'd0);
    chk("single_valid_c2", 32'(rsp_valid), 32'd0);
    cyc();
    chk("single_valid_c3", 32'(rsp_valid), 32'd1);
    chk("single_bid", 32'(rsp_bid), 32'h5);
    chk("single_bresp", 32'(rsp_bresp), 32'h2);
    chk("single_slverr_cnt", 32'(slverr_cnt), 32'd1);
    cyc();
    chk("single_valid_drop", 32'(rsp_valid), 32'd0);
    last_bid = 4'h5; last_bresp = 2'd2;

    // Backpressure: one pop, fields held, next pop only after handshake
    rsp_ready = 1'b0;
    push(mk(8'hAA, 4'hC, 4'h1, 8'h53, 104'h0));
    push(mk(8'hAA, 4'h9, 4'h3, 8'h53, 104'h0));
    n_re = 0; n_unstable = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (read_enable) n_re++;
    end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (read_enable) n_re++;
      if (!rsp_valid || rsp_bid != 4'hC || rsp_bresp != 2'd1) n_unstable++;
    end
    chk("bp_read_pulses", 32'(n_re), 32'd1);
    chk("bp_unstable_cycles", 32'(n_unstable), 32'd0);
    rsp_ready = 1'b1;
    cyc();
    chk("bp_valid_after_hs", 32'(rsp_valid), 32'd0);
    cyc();
    chk("bp_next_pop", 32'(read_enable), 32'd1);
    cyc(); cyc();
    chk("bp_second_valid", 32'(rsp_valid), 32'd1);
    chk("bp_second_bid", 32'(rsp_bid), 32'h9);
    chk("bp_second_bresp", 32'(rsp_bresp), 32'h3);
    cyc();
    last_bid = 4'h9; last_bresp = 2'd3;

    // Three malformed packets back to back
    do_clear();
    push(mk(8'hAB, 4'h1, 4'h0, 8'h53, 104'h0));
    push(mk(8'hAA, 4'h1, 4'h0, 8'h5B, 104'h0));
    push(mk(8'hAA, 4'h1, 4'h0, 8'h53, 104'h1));
    n_fe = 0; n_val = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (frame_err) n_fe++;
      if (rsp_valid) n_val++;
    end
    chk("bad_frame_err_pulses", 32'(n_fe), 32'd3);
    chk("bad_frame_err_cnt", 32'(frame_err_cnt), 32'd3);
    chk("bad_valid_cycles", 32'(n_val), 32'd0);
    chk("bad_fields_unchanged", 32'({rsp_bid, rsp_bresp}), 32'({last_bid, last_bresp}));

    // BRESP sweep, 4-cycle spacing
    do_clear();
    push(mk(8'hAA, 4'h1, 4'h0, 8'h53, 104'h0));
    push(mk(8'hAA, 4'h2, 4'h1, 8'h53, 104'h0));
    push(mk(8'hAA, 4'h3, 4'h2, 8'h53, 104'h0));
    push(mk(8'hAA, 4'h4, 4'h3, 8'h53, 104'h0));
    n_val = 0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (rsp_valid && n_val < 4) begin
        v_cyc[n_val] = c;
        v_val[n_val] = {rsp_bid, rsp_bresp};
        n_val++;
      end
    end
    chk("sweep_count", 32'(n_val), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("sweep_cycle", 32'(v_cyc[k]), 32'(3 + 4 * k));
      chk("sweep_fields", 32'(v_val[k]), 32'({4'(k + 1), 2'(k)}));
    end
    chk("sweep_okay_cnt", 32'(okay_cnt), 32'd2);
    chk("sweep_slverr_cnt", 32'(slverr_cnt), 32'd1);
    chk("sweep_decerr_cnt", 32'(decerr_cnt), 32'd1);
    last_bid = 4'h4; last_bresp = 2'd3;

    // Table-driven vectors
    do_clear();
    e_ok = 0; e_slv = 0; e_dec = 0; e_fe = 0;
    for (int v = 0; v < 9; v++) begin
      push(vt[v].pkt);
      wait_out("tbl");
      chk("tbl_valid", 32'(rsp_valid), 32'(vt[v].good));
      chk("tbl_frame_err", 32'(frame_err), 32'(!vt[v].good));
      if (vt[v].good) begin
        last_bid = vt[v].bid; last_bresp = vt[v].bresp;
        if (vt[v].bresp[1] == 1'b0) e_ok++;
        else if (vt[v].bresp == 2'd2) e_slv++;
        else e_dec++;
      end else begin
        e_fe++;
      end
      chk("tbl_fields", 32'({rsp_bid, rsp_bresp}), 32'({last_bid, last_bresp}));
      cyc();
      chk("tbl_pulse_end", 32'(frame_err | rsp_valid), 32'd0);
    end
    chk("tbl_okay_cnt", 32'(okay_cnt), 32'(e_ok));
    chk("tbl_slverr_cnt", 32'(slverr_cnt), 32'(e_slv));
    chk("tbl_decerr_cnt", 32'(decerr_cnt), 32'(e_dec));
    chk("tbl_frame_err_cnt", 32'(frame_err_cnt), 32'(e_fe));

    // Saturation from a preloaded count, then clear against an increment
    do_clear();
    force dut.r_okay_cnt = 16'hFFFE;
    cyc();
    release dut.r_okay_cnt;
    for (int k = 0; k < 3; k++) begin
      push(mk(8'hAA, 4'h2, 4'h0, 8'h53, 104'h0));
      wait_out("sat");
      chk("sat_okay_cnt", 32'(okay_cnt), 32'hFFFF);
      cyc();
    end
    push(mk(8'hAA, 4'h6, 4'h1, 8'h53, 104'h0));
    cyc(); cyc();
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    chk("clr_vs_inc_okay_cnt", 32'(okay_cnt), 32'd0);
    chk("clr_fsm_valid", 32'(rsp_valid), 32'd1);
    chk("clr_fsm_bid", 32'(rsp_bid), 32'h6);
    cyc();

    // Reset while holding a response
    rsp_ready = 1'b0;
    push(mk(8'hAA, 4'hD, 4'h1, 8'h53, 104'h0));
    wait_out("rst_out");
    chk("rst_out_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(rsp_valid), 32'd0);
    chk("rst_out_fields", 32'({rsp_bid, rsp_bresp}), 32'd0);
    chk("rst_out_okay_cnt", 32'(okay_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    push(mk(8'hAA, 4'h3, 4'h0, 8'h53, 104'h0));
    wait_out("rst_after");
    chk("rst_after_bid", 32'({rsp_valid, rsp_bid, rsp_bresp}), 32'({1'b1, 4'h3, 2'd0}));
    cyc();
    chk("rst_after_okay_cnt", 32'(okay_cnt), 32'd1);

    // Randomized run against a packet-level model
    do_clear();
    e_ok = 0; e_slv = 0; e_dec = 0; e_fe = 0;
    exp_q.delete();
    for (int p = 0; p < 60; p++) begin
      logic [7:0]   sop, eop;
      logic [3:0]   bid, br;
      logic [103:0] low, one;
      int           kind;
      kind = $urandom_range(0, 5);
      sop = 8'hAA; eop = 8'h53; low = '0; one = 104'h1;
      bid = 4'($urandom); br = {2'b00, 2'($urandom)};
      case (kind)
        2: sop = sop ^ 8'($urandom_range(1, 255));
        3: eop = eop ^ 8'($urandom_range(1, 255));
        4: br[3:2] = 2'($urandom_range(1, 3));
        5: low = one << $urandom_range(0, 103);
        default: ;
      endcase
      push(mk(sop, bid, br, eop, low));
      if (sop == 8'hAA && eop == 8'h53 && br[3:2] == 2'b00 && low == '0) begin
        exp_q.push_back({bid, br[1:0]});
        if (br[1] == 1'b0) e_ok++;
        else if (br[0] == 1'b0) e_slv++;
        else e_dec++;
      end else begin
        e_fe++;
      end
    end
    begin
      int n_good, got, fe_seen, re_out;
      n_good = exp_q.size(); got = 0; fe_seen = 0; re_out = 0;
      for (int c = 0; c < 4000; c++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (rsp_valid) begin
          chk("rnd_rsp_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("rnd_rsp_fields", 32'({rsp_bid, rsp_bresp}), 32'(exp_q[0]));
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              got++;
            end
          end
        end
        if (frame_err) fe_seen++;
        if (read_enable && rsp_valid) re_out++;
        cyc();
        if (got == n_good && fe_seen == e_fe && wp == rp) break;
      end
      chk("rnd_responses", 32'(got), 32'(n_good));
      chk("rnd_frame_errs", 32'(fe_seen), 32'(e_fe));
      chk("rnd_read_in_out", 32'(re_out), 32'd0);
      chk("rnd_okay_cnt", 32'(okay_cnt), 32'(e_ok));
      chk("rnd_slverr_cnt", 32'(slverr_cnt), 32'(e_slv));
      chk("rnd_decerr_cnt", 32'(decerr_cnt), 32'(e_dec));
      chk("rnd_frame_err_cnt", 32'(frame_err_cnt), 32'(e_fe));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wr_rsp_fifo_reader.md
Name: wr_rsp_fifo_reader

Overview:
Downstream consumer of the write-response FIFO. Pops one 128-bit write-response packet at a time and checks its framing. Decodes the BID and BRESP fields and presents them on a valid/ready interface to the host side of the BFM. Keeps saturating statistics for response types and framing errors.

Parameters:
id_wid, 4, BID width; legal range 1..8; sets the packet field positions.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  response FIFO empty flag
fifo_rdata  input  128  FIFO read data; valid the cycle after read_enable is high
read_enable  output  1  FIFO pop strobe; registered; one cycle per packet
rsp_valid  output  1  decoded response available
rsp_ready  input  1  host accepts the response
rsp_bid  output  id_wid  decoded BID
rsp_bresp  output  2  decoded BRESP
frame_err  output  1  one-cycle pulse when a malformed packet is dropped
clear_stats  input  1  synchronous clear of all counters
okay_cnt  output  16  count of OKAY/EXOKAY responses, saturating
slverr_cnt  output  16  count of SLVERR responses, saturating
decerr_cnt  output  16  count of DECERR responses, saturating
frame_err_cnt  output  16  count of dropped malformed packets, saturating

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE.
- Packet layout, MSB first:
  - [127:120] SOP = 8'hAA
  - next id_wid bits: BID
  - next 4 bits: BRESP; bits [3:2] must be 0
  - next 8 bits: EOP = 8'h53
  - all remaining low bits must be 0
  - With id_wid=4: SOP [127:120], BID [119:116], BRESP [115:112], EOP [111:104], zero [103:0].
- FSM states: IDLE, RD, CAP, OUT.
- IDLE:
  - fifo_empty==0 → RD. read_enable=1 during RD only.
  - fifo_empty==1 → stay in IDLE; read_enable stays 0.
- RD → CAP unconditionally. fifo_empty is ignored in RD and CAP.
- CAP (fifo_rdata valid):
  - Framing good when SOP, EOP, BRESP[3:2] and reserved bits all match the layout above.
  - Good: register rsp_bid and rsp_bresp; rsp_valid<=1; → OUT.
  - Bad: frame_err<=1 for one cycle; → IDLE; rsp_valid stays 0; rsp_bid/rsp_bresp unchanged.
- OUT:
  - Hold rsp_valid, rsp_bid and rsp_bresp stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid<=0; → IDLE.
  - No further FIFO read while in OUT.
- Latency: fifo_empty falls in cycle 0 → read_enable high in cycle 1 → rsp_valid high in cycle 3. Minimum packet interval is 4 cycles when rsp_ready is held high.
- Counters:
  - Updated at the CAP evaluation, independent of host acceptance.
  - Good packet with BRESP 00 or 01 → okay_cnt+1; 10 → slverr_cnt+1; 11 → decerr_cnt+1.
  - Bad packet → frame_err_cnt+1.
  - All counters saturate at 16'hFFFF.
  - clear_stats zeroes all four counters next cycle; clear wins over a simultaneous increment.
  - clear_stats does not affect the FSM or the rsp_* outputs.
- Reset mid-operation: a packet already popped but not yet accepted by the host is lost. This is required behaviour; no recovery.

Test Plan:
- Single good packet: fifo_rdata={8'hAA,4'h5,4'h2,8'h53,104'h0}, rsp_ready=1 → read_enable in cycle 1; rsp_valid in cycle 3 with rsp_bid=5, rsp_bresp=2'b10; slverr_cnt=1.
- Backpressure: rsp_ready=0 for 10 cycles, FIFO non-empty → rsp_valid and fields held stable; exactly one read_enable pulse until the handshake, then the next pop.
- Bad SOP (8'hAB), then bad EOP, then reserved bit 0 set → three frame_err pulses; frame_err_cnt=3; rsp_valid never asserted; rsp_* unchanged.
- BRESP sweep 00/01/10/11 back-to-back with rsp_ready=1 → okay_cnt=2, slverr_cnt=1, decerr_cnt=1; packets 4 cycles apart.
- Saturation and clear: preload okay_cnt=16'hFFFE with 3 OKAY packets → counter holds at FFFF; clear_stats asserted in the same cycle as an increment → counter reads 0.
- Reset in OUT with rsp_valid=1 → all outputs 0 immediately; after release, the next FIFO word is processed normally.
